// File: rtl/seq_taillight_controller.sv
// seq_taillight_controller
//
// Sequential tail-light controller for one rear lamp cluster pair. It drives
// LAMPS bulbs per side from the brake, turn and hazard inputs. The active turn
// side (or both sides in hazard) steps through a fill pattern, advancing one
// phase every STEP_CYCLES clocks. With brake applied, the sequencing side
// shows the inverted pattern and any non-sequencing side is held fully on.
//
// Ports
//   clk          in   system clock
//   rst_n        in   asynchronous active-low reset
//   brake        in   brake pedal
//   turn_left    in   left indicator
//   turn_right   in   right indicator
//   hazard       in   hazard switch
//   left_lamps   out  [LAMPS-1:0] left bulb enables (bit 0 innermost)
//   right_lamps  out  [LAMPS-1:0] right bulb enables (bit 0 innermost)
//   seq_wrap     out  one-cycle pulse after the phase wraps from LAMPS to 0
//
// The lamp outputs are decoded from registered state only (sampled inputs
// and phase), so they change exactly one cycle after an input change and
// drop to zero as soon as reset is asserted.

module seq_taillight_controller #(
  parameter int LAMPS       = 3,
  parameter int STEP_CYCLES = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             brake,
  input  logic             turn_left,
  input  logic             turn_right,
  input  logic             hazard,
  output logic [LAMPS-1:0] left_lamps,
  output logic [LAMPS-1:0] right_lamps,
  output logic             seq_wrap
);

  localparam int CNT_W = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam int PH_W  = $clog2(LAMPS + 1);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STEP_CYCLES - 1);
  localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(LAMPS);

  typedef enum logic [1:0] {
    MODE_STATIC = 2'd0,
    MODE_LEFT   = 2'd1,
    MODE_RIGHT  = 2'd2,
    MODE_HAZ    = 2'd3
  } mode_e;

  // Sampled inputs, packed as {hazard, brake, turn_right, turn_left}.
  logic [3:0]       in_d;
  logic [3:0]       in_q;
  logic [CNT_W-1:0] cnt_q;
  logic [PH_W-1:0]  phase_q;
  logic             seq_wrap_q;

  mode_e            mode;
  logic             brake_q;
  logic [LAMPS-1:0] turn_pat;
  logic [LAMPS-1:0] seq_pat;
  logic [LAMPS-1:0] solid_pat;

  assign in_d    = {hazard, brake, turn_right, turn_left};
  assign brake_q = in_q[2];

  // Mode decode: both turn signals together behave as hazard.
  always_comb begin
    mode = MODE_STATIC;
    if (in_q[3] || (in_q[0] && in_q[1])) begin
      mode = MODE_HAZ;
    end else if (in_q[0]) begin
      mode = MODE_LEFT;
    end else if (in_q[1]) begin
      mode = MODE_RIGHT;
    end
  end

  // Fill pattern: phase k lights bulbs 0..k; the final phase (LAMPS) is dark.
  always_comb begin
    turn_pat = '0;
    for (int i = 0; i < LAMPS; i++) begin
      turn_pat[i] = (phase_q != PH_LAST) && (phase_q >= PH_W'(i));
    end
  end

  assign seq_pat   = brake_q ? ~turn_pat : turn_pat;
  assign solid_pat = {LAMPS{brake_q}};

  always_comb begin
    left_lamps  = solid_pat;
    right_lamps = solid_pat;
    case (mode)
      MODE_LEFT:  left_lamps  = seq_pat;
      MODE_RIGHT: right_lamps = seq_pat;
      MODE_HAZ: begin
        left_lamps  = seq_pat;
        right_lamps = seq_pat;
      end
      default: ;
    endcase
  end

  assign seq_wrap = seq_wrap_q;

  // Any change of the raw inputs restarts the sequence at phase 0, even if
  // the decoded mode is unchanged; that restart outranks a pending wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_q       <= '0;
      cnt_q      <= '0;
      phase_q    <= '0;
      seq_wrap_q <= 1'b0;
    end else if (in_d != in_q) begin
      in_q       <= in_d;
      cnt_q      <= '0;
      phase_q    <= '0;
      seq_wrap_q <= 1'b0;
    end else if (mode == MODE_STATIC) begin
      cnt_q      <= '0;
      phase_q    <= '0;
      seq_wrap_q <= 1'b0;
    end else if (cnt_q == CNT_LAST) begin
      cnt_q <= '0;
      if (phase_q == PH_LAST) begin
        phase_q    <= '0;
        seq_wrap_q <= 1'b1;
      end else begin
        phase_q    <= phase_q + 1'b1;
        seq_wrap_q <= 1'b0;
      end
    end else begin
      cnt_q      <= cnt_q + 1'b1;
      seq_wrap_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_seq_taillight_controller.sv
// Bench for seq_taillight_controller. Four instances share the same inputs:
// the default LAMPS=3/STEP_CYCLES=5 unit plus LAMPS/STEP_CYCLES of 1/1, 4/2
// and 8/7. The driver pushes the expected output vector (with a care mask)
// for the cycle after each clock edge; the monitor pops and compares on the
// falling edge.

module tb_seq_taillight_controller;

  localparam int W = 36;

  // Observation vector layout:
  //   [35:33] m_l  [32:30] m_r  [29] m_w   (LAMPS=3, STEP=5)
  //   [28] a_l [27] a_r [26] a_w           (LAMPS=1, STEP=1)
  //   [25:22] b_l [21:18] b_r [17] b_w     (LAMPS=4, STEP=2)
  //   [16:9] c_l [8:1] c_r [0] c_w         (LAMPS=8, STEP=7)
  localparam logic [W-1:0] MAIN_MASK = {7'h7f, 29'd0};
  localparam logic [W-1:0] ALL_MASK  = {W{1'b1}};

  logic clk = 1'b0;
  logic rst_n, brake, turn_left, turn_right, hazard;

  logic [2:0] m_l, m_r;
  logic       m_w;
  logic [0:0] a_l, a_r;
  logic       a_w;
  logic [3:0] b_l, b_r;
  logic       b_w;
  logic [7:0] c_l, c_r;
  logic       c_w;
  logic [W-1:0] obs;

  assign obs = {m_l, m_r, m_w, a_l, a_r, a_w, b_l, b_r, b_w, c_l, c_r, c_w};

  // Clock
  always #5 clk = ~clk;

  seq_taillight_controller #(.LAMPS(3), .STEP_CYCLES(5)) u_main (
    .clk(clk), .rst_n(rst_n), .brake(brake), .turn_left(turn_left),
    .turn_right(turn_right), .hazard(hazard),
    .left_lamps(m_l), .right_lamps(m_r), .seq_wrap(m_w));

  seq_taillight_controller #(.LAMPS(1), .STEP_CYCLES(1)) u_a (
    .clk(clk), .rst_n(rst_n), .brake(brake), .turn_left(turn_left),
    .turn_right(turn_right), .hazard(hazard),
    .left_lamps(a_l), .right_lamps(a_r), .seq_wrap(a_w));

  seq_taillight_controller #(.LAMPS(4), .STEP_CYCLES(2)) u_b (
    .clk(clk), .rst_n(rst_n), .brake(brake), .turn_left(turn_left),
    .turn_right(turn_right), .hazard(hazard),
    .left_lamps(b_l), .right_lamps(b_r), .seq_wrap(b_w));

  seq_taillight_controller #(.LAMPS(8), .STEP_CYCLES(7)) u_c (
    .clk(clk), .rst_n(rst_n), .brake(brake), .turn_left(turn_left),
    .turn_right(turn_right), .hazard(hazard),
    .left_lamps(c_l), .right_lamps(c_r), .seq_wrap(c_w));

  // Scoreboard
  logic [W-1:0] exp_q[$];
  logic [W-1:0] mask_q[$];
  string        name_q[$];
  int           n_cmp = 0;
  int           n_err = 0;

  logic [2:0] t_tab[4];
  logic [2:0] b_tab[4];

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [W-1:0] e, m;
      string nm;
      e  = exp_q.pop_front();
      m  = mask_q.pop_front();
      nm = name_q.pop_front();
      n_cmp++;
      if ((obs & m) !== (e & m)) begin
        n_err++;
        $display("FAIL %s @%0t: got %h expected %h (mask %h)", nm, $time, obs & m, e & m, m);
      end
    end
  end

  // Driver tasks
  task automatic push(input logic [W-1:0] e, input logic [W-1:0] m, input string nm);
    exp_q.push_back(e);
    mask_q.push_back(m);
    name_q.push_back(nm);
  endtask

  // Expect a value on the outputs after the next clock edge.
  task automatic chk(input logic [W-1:0] e, input logic [W-1:0] m, input string nm);
    @(posedge clk);
    #1;
    push(e, m, nm);
  endtask

  task automatic chk_main(input logic [2:0] l, input logic [2:0] r, input logic w, input string nm);
    chk({l, r, w, 29'd0}, MAIN_MASK, nm);
  endtask

  // Turn fill pattern for a given lamp count and phase.
  function automatic logic [7:0] tpat(input int lamps, input int ph);
    return (ph < lamps) ? 8'((1 << (ph + 1)) - 1) : 8'd0;
  endfunction

  // Expected outputs of all instances n cycles into a left-turn sequence.
  function automatic logic [W-1:0] exp_left(input int n);
    logic [7:0] tm, ta, tb, tc;
    logic wm, wa, wb, wc;
    tm = tpat(3, (n / 5) % 4);
    ta = tpat(1, n % 2);
    tb = tpat(4, (n / 2) % 5);
    tc = tpat(8, (n / 7) % 9);
    wm = (n > 0) && (n % 20 == 0);
    wa = (n > 0) && (n % 2 == 0);
    wb = (n > 0) && (n % 10 == 0);
    wc = (n > 0) && (n % 63 == 0);
    return {tm[2:0], 3'b000, wm, ta[0], 1'b0, wa, tb[3:0], 4'h0, wb, tc, 8'h00, wc};
  endfunction

  initial begin
    t_tab = '{3'b001, 3'b011, 3'b111, 3'b000};
    b_tab = '{3'b110, 3'b100, 3'b000, 3'b111};
    rst_n = 1'b0;
    brake = 1'b0;
    turn_left = 1'b0;
    turn_right = 1'b0;
    hazard = 1'b0;

    // Reset state
    chk('0, ALL_MASK, "reset");
    chk('0, ALL_MASK, "reset");
    rst_n = 1'b1;
    chk('0, ALL_MASK, "idle");

    // Left turn on every instance, two full sequences of the longest one
    turn_left = 1'b1;
    for (int n = 0; n < 130; n++) chk(exp_left(n), ALL_MASK, "left_seq");

    // Brake with right turn
    turn_left = 1'b0;
    turn_right = 1'b1;
    brake = 1'b1;
    for (int n = 0; n <= 20; n++)
      chk_main(3'b111, b_tab[(n / 5) % 4], (n == 20), "brake_right");

    // Hazard, then brake added at cycle 7
    turn_right = 1'b0;
    brake = 1'b0;
    hazard = 1'b1;
    for (int n = 0; n < 7; n++) chk_main(t_tab[n / 5], t_tab[n / 5], 1'b0, "hazard");
    brake = 1'b1;
    for (int n = 0; n < 10; n++) chk_main(b_tab[n / 5], b_tab[n / 5], 1'b0, "hazard_brake");

    // Right turn, switched to left on the wrap edge
    brake = 1'b0;
    hazard = 1'b0;
    turn_right = 1'b1;
    for (int n = 0; n < 20; n++) chk_main(3'b000, t_tab[n / 5], 1'b0, "right_seq");
    turn_right = 1'b0;
    turn_left = 1'b1;
    for (int n = 0; n < 7; n++) chk_main(t_tab[n / 5], 3'b000, 1'b0, "switch_on_wrap");

    // Single-cycle hazard glitch
    hazard = 1'b1;
    chk_main(3'b001, 3'b001, 1'b0, "glitch_on");
    hazard = 1'b0;
    for (int n = 0; n < 6; n++) chk_main(t_tab[n / 5], 3'b000, 1'b0, "glitch_off");

    // Both turns act as hazard; toggling hazard still restarts
    turn_right = 1'b1;
    for (int n = 0; n < 6; n++) chk_main(t_tab[n / 5], t_tab[n / 5], 1'b0, "both_turns");
    hazard = 1'b1;
    for (int n = 0; n < 3; n++) chk_main(3'b001, 3'b001, 1'b0, "haz_toggle");

    // Static brake, then asynchronous reset mid-cycle
    turn_left = 1'b0;
    turn_right = 1'b0;
    hazard = 1'b0;
    brake = 1'b1;
    for (int n = 0; n < 3; n++) chk_main(3'b111, 3'b111, 1'b0, "brake_static");
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    push('0, ALL_MASK, "async_rst");
    chk('0, ALL_MASK, "rst_hold");
    rst_n = 1'b1;
    chk({3'b111, 3'b111, 1'b0, 1'b1, 1'b1, 1'b0, 4'hf, 4'hf, 1'b0, 8'hff, 8'hff, 1'b0},
        ALL_MASK, "rst_release");

    repeat (3) @(posedge clk);
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
